apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_pkg.sv | 30 +++
 rtl/apb_wait_counter.sv | 47 ++++
 rtl/apb_slave_mem.sv | 173 +++++++++++++++++
 tb/tb_apb_slave_mem.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slave_pkg
//  Description : Shared types, default parameters and address helpers for the
//                APB slave memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_slave_pkg;

   // Two-state transfer FSM
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_e;

   localparam int DEF_ADDR_WIDTH  = 32;
   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_MEM_DEPTH   = 64;
   localparam int DEF_WAIT_STATES = 2;

   // Wide enough for the largest wait-state setting (15)
   localparam int CNT_WIDTH = 4;

   // Byte address to word index (words are 4 bytes wide)
   function automatic logic [63:0] word_index(input logic [63:0] byte_addr);
      return byte_addr >> 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_wait_counter
//  Description : Loadable down-counter that paces APB wait states. Reports
//                both the current and the next-cycle zero condition so the
//                parent can register pready exactly when the count expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_zero,
   output logic             o_next_zero
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: load wins over decrement; the count saturates at zero
   always_comb begin
      count_d = count_q;
      if (i_load) begin
         count_d = i_load_val;
      end else if (i_en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   assign o_zero      = (count_q == '0);
   assign o_next_zero = (count_d == '0);

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slave_mem
//  Description : APB slave backed by a register-array memory with byte
//                strobes, programmable wait states and error response on
//                misaligned or out-of-range addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_mem
   import apb_slave_pkg::*;
#(
   parameter int ADDR_WIDTH  = apb_slave_pkg::DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = apb_slave_pkg::DEF_DATA_WIDTH,
   parameter int MEM_DEPTH   = apb_slave_pkg::DEF_MEM_DEPTH,
   parameter int WAIT_STATES = apb_slave_pkg::DEF_WAIT_STATES
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   apb_state_e              state_q,   state_d;
   logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
   logic                    write_q,   write_d;
   logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
   logic [STRB_WIDTH-1:0]   strb_q,    strb_d;
   logic                    pready_q,  pready_d;
   logic                    pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0]   prdata_q,  prdata_d;

   logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

   logic                    cnt_load;
   logic                    cnt_en;
   logic                    cnt_zero;
   logic                    cnt_next_zero;

   logic                    legal_cur;
   logic                    legal_next;
   logic [IDX_WIDTH-1:0]    idx_cur;
   logic [IDX_WIDTH-1:0]    idx_next;
   logic                    mem_we;
   logic [DATA_WIDTH-1:0]   mem_wword;

   // Word-aligned and inside the array
   function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
      return (a[1:0] == 2'b00) && (word_index(64'(a)) < 64'(MEM_DEPTH));
   endfunction

   apb_wait_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_wait_counter (
      .clk         (pclk),
      .rst         (preset),
      .i_load      (cnt_load),
      .i_load_val  (CNT_WIDTH'(WAIT_STATES)),
      .i_en        (cnt_en),
      .o_zero      (cnt_zero),
      .o_next_zero (cnt_next_zero)
   );

   // Transfer sequencing: latch on setup, count wait states, complete or abort
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      mem_we   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A select with penable already high lacks a setup phase: ignore
            if (psel && !penable) begin
               state_d  = ST_ACCESS;
               addr_d   = paddr;
               write_d  = pwrite;
               wdata_d  = pwdata;
               strb_d   = pstrb;
               cnt_load = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (!psel) begin
               state_d = ST_IDLE;
            end else if (penable && pready_q) begin
               state_d = ST_IDLE;
               mem_we  = write_q && legal_cur;
            end else begin
               cnt_en  = !cnt_zero;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign legal_cur  = addr_legal(addr_q);
   assign legal_next = addr_legal(addr_d);
   assign idx_cur    = IDX_WIDTH'(word_index(64'(addr_q)));
   assign idx_next   = IDX_WIDTH'(word_index(64'(addr_d)));

   // Response outputs are only non-zero in the cycle pready is high
   always_comb begin
      pready_d  = (state_d == ST_ACCESS) && cnt_next_zero;
      pslverr_d = pready_d && !legal_next;
      prdata_d  = '0;
      if (pready_d && !write_d && legal_next) begin
         prdata_d = mem_q[idx_next];
      end
   end

   // Merge strobed write lanes into the addressed word
   always_comb begin
      mem_wword = mem_q[idx_cur];
      for (int b = 0; b < STRB_WIDTH; b++) begin
         if (strb_q[b]) begin
            mem_wword[8*b +: 8] = wdata_q[8*b +: 8];
         end
      end
   end

   // Control and response registers
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   // Memory array: cleared by reset, written only at a legal write completion
   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[idx_cur] <= mem_wword;
      end
   end

   assign pready  = pready_q;
   assign pslverr = pslverr_q;
   assign prdata  = prdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_slave_mem
//  Description : Scoreboard bench for apb_slave_mem. Two instances are
//                exercised (0 and 2 wait states) against an array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_mem;

   localparam int DEPTH = 64;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        preset;
   logic [1:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [1:0]  pready;
   logic [1:0]  pslverr;
   logic [31:0] prdata_a [2];

   logic [31:0] model [2][DEPTH];
   exp_t        q0[$];
   exp_t        q1[$];
   int          acc [2];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   // Instance 0: zero wait states
   apb_slave_mem #(
      .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_DEPTH (DEPTH), .WAIT_STATES (0)
   ) u_dut0 (
      .pclk (clk), .preset (preset), .psel (psel[0]), .penable (penable),
      .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb),
      .pready (pready[0]), .prdata (prdata_a[0]), .pslverr (pslverr[0])
   );

   // Instance 1: two wait states
   apb_slave_mem #(
      .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_DEPTH (DEPTH), .WAIT_STATES (2)
   ) u_dut2 (
      .pclk (clk), .preset (preset), .psel (psel[1]), .penable (penable),
      .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb),
      .pready (pready[1]), .prdata (prdata_a[1]), .pslverr (pslverr[1])
   );

   function automatic logic legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 2; i++)
         for (int w = 0; w < DEPTH; w++)
            model[i][w] = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One APB transfer; drop_at>0 deasserts psel in that access cycle (abort).
   // Starts driving setup immediately so consecutive calls are back-to-back.
   task automatic xfer(input int inst, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input int drop_at);
      exp_t        e;
      int          cyc;
      logic [31:0] w;
      int          idx;
      if (drop_at == 0) begin
         e.err   = !legal(a);
         e.rdata = '0;
         if (legal(a)) begin
            idx = int'(a >> 2);
            if (wr) begin
               w = model[inst][idx];
               for (int b = 0; b < 4; b++)
                  if (s[b]) w[8*b +: 8] = d[8*b +: 8];
               model[inst][idx] = w;
            end else begin
               e.rdata = model[inst][idx];
            end
         end
         if (inst == 0) q0.push_back(e);
         else           q1.push_back(e);
      end
      psel       = '0;
      psel[inst] = 1'b1;
      penable    = 1'b0;
      pwrite     = wr;
      paddr      = a;
      pwdata     = d;
      pstrb      = s;
      @(posedge clk);
      #1;
      penable = 1'b1;
      // Inputs wander during the access phase; only the latched copy matters
      paddr   = $urandom;
      pwdata  = $urandom;
      pstrb   = 4'($urandom);
      pwrite  = 1'($urandom);
      if (drop_at > 0) begin
         for (int k = 1; k < drop_at; k++) begin
            @(negedge clk);
            n_tests++;
            if (pready[inst] !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_pre_drop: pready=%b required 0", pready[inst]);
            end
            @(posedge clk);
            #1;
         end
         psel    = '0;
         penable = 1'b0;
         @(negedge clk);
         n_tests++;
         if (pready[inst] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_drop_cycle: pready=%b required 0", pready[inst]);
         end
         @(posedge clk);
         #1;
      end else begin
         cyc = 0;
         forever begin
            @(negedge clk);
            if (pready[inst] === 1'b1) break;
            cyc++;
            if (cyc > 40) begin
               n_tests++;
               n_fail++;
               $display("FAIL pready_timeout: inst=%0d waited %0d cycles required <=3", inst, cyc);
               break;
            end
         end
         @(posedge clk);
         #1;
         psel    = '0;
         penable = 1'b0;
      end
   endtask

   // Monitor: every pready cycle is matched against the scoreboard;
   // outside pready cycles the response outputs must be zero.
   always @(negedge clk) begin
      if (preset === 1'b0) begin
         for (int i = 0; i < 2; i++) begin
            exp_t e;
            int   ws;
            ws = (i == 1) ? 2 : 0;
            if (pready[i] === 1'b1) begin
               n_tests++;
               if (!(psel[i] && penable)) begin
                  n_fail++;
                  $display("FAIL pready_outside_access: inst=%0d psel=%b penable=%b required psel=1 penable=1",
                           i, psel[i], penable);
               end else if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  n_fail++;
                  $display("FAIL unexpected_pready: inst=%0d pready=1 required 0", i);
               end else begin
                  e = (i == 0) ? q0.pop_front() : q1.pop_front();
                  if (prdata_a[i] !== e.rdata) begin
                     n_fail++;
                     $display("FAIL prdata: inst=%0d got %h required %h", i, prdata_a[i], e.rdata);
                  end
                  n_tests++;
                  if (pslverr[i] !== e.err) begin
                     n_fail++;
                     $display("FAIL pslverr: inst=%0d got %b required %b", i, pslverr[i], e.err);
                  end
                  n_tests++;
                  if (acc[i] + 1 != ws + 1) begin
                     n_fail++;
                     $display("FAIL access_length: inst=%0d got %0d cycles required %0d", i, acc[i] + 1, ws + 1);
                  end
               end
               acc[i] = 0;
            end else begin
               n_tests++;
               if (prdata_a[i] !== 32'h0 || pslverr[i] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL idle_outputs: inst=%0d prdata=%h pslverr=%b required 0/0",
                           i, prdata_a[i], pslverr[i]);
               end
               if (psel[i] && penable) acc[i] = acc[i] + 1;
               else                    acc[i] = 0;
            end
         end
      end
   end

   task automatic check_zero_outputs(input string name);
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if (pready[i] !== 1'b0 || pslverr[i] !== 1'b0 || prdata_a[i] !== 32'h0) begin
            n_fail++;
            $display("FAIL %s: inst=%0d pready=%b pslverr=%b prdata=%h required all 0",
                     name, i, pready[i], pslverr[i], prdata_a[i]);
         end
      end
   endtask

   initial begin
      int          inst;
      int          r;
      logic [31:0] a;
      acc[0]  = 0;
      acc[1]  = 0;
      preset  = 1'b1;
      psel    = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      clear_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero_outputs("reset_state");
      @(posedge clk);
      #1;
      preset = 1'b0;

      // First transfer right after reset, then read back (2 wait states)
      xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
      idle(1);

      // Byte strobes merge into an existing word
      xfer(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
      xfer(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0);
      xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 0);
      idle(2);

      // Error responses and an all-zero strobe write
      xfer(1, 1'b0, 32'h100, 32'h0, 4'h0, 0);
      xfer(1, 1'b1, 32'h0A, 32'hFFFFFFFF, 4'hF, 0);
      xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 0);
      xfer(1, 1'b1, 32'h10, 32'h12345678, 4'h0, 0);
      xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
      idle(1);

      // Abort in the second access cycle, then confirm no write took place
      xfer(1, 1'b1, 32'h04, 32'hCAFEF00D, 4'hF, 2);
      idle(1);
      xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 0);
      idle(1);

      // Select with penable already high and no setup phase is ignored
      psel    = 2'b11;
      penable = 1'b1;
      paddr   = 32'h0;
      pwrite  = 1'b0;
      idle(3);
      psel    = '0;
      penable = 1'b0;
      idle(1);

      // Reset in the middle of an access phase
      psel    = 2'b10;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h04;
      pwdata  = 32'h55AA55AA;
      pstrb   = 4'hF;
      @(posedge clk);
      #1;
      penable = 1'b1;
      @(posedge clk);
      #1;
      preset  = 1'b1;
      psel    = '0;
      penable = 1'b0;
      @(negedge clk);
      check_zero_outputs("reset_mid_access");
      @(posedge clk);
      #1;
      preset = 1'b0;
      acc[0] = 0;
      acc[1] = 0;
      clear_model();
      xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 0);
      xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
      idle(1);

      // Zero wait states: back-to-back write then read
      xfer(0, 1'b1, 32'h0, 32'h5, 4'hF, 0);
      xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
      idle(1);

      // Randomized traffic on both instances
      for (int n = 0; n < 300; n++) begin
         inst = int'($urandom_range(0, 1));
         r    = int'($urandom_range(0, 9));
         if (r < 8) a = 32'($urandom_range(0, DEPTH + 3)) << 2;
         else       a = 32'($urandom_range(0, 32'h11F));
         if (inst == 1 && $urandom_range(0, 14) == 0)
            xfer(1, 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(1, 2)));
         else
            xfer(inst, 1'($urandom), a, $urandom, 4'($urandom), 0);
         idle(int'($urandom_range(0, 2)));
      end

      idle(3);
      n_tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: pending %0d/%0d required 0/0", q0.size(), q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation time exceeded");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
